demux_1x64_framer: RTL and testbench



---
 rtl/demux_1x64_framer.sv | 86 ++++++++
 tb/tb_demux_1x64_framer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/demux_1x64_framer.sv
// Registered 1:64 lane demux with frame tracking; writes land one cycle after acceptance.
// in_ready drops while the frame is FULL (until frame_ack) and whenever clear is high.
module demux_1x64_framer #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    din,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           s,
    input  logic                 mode,
    input  logic                 clear,
    input  logic                 frame_ack,
    output logic [64*DATA_W-1:0] y,
    output logic [63:0]          y_valid,
    output logic [5:0]           ptr,
    output logic                 frame_done
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t      state;
    logic        accept;
    logic [5:0]  lane;
    logic [7:0]  grp_sel;
    logic [7:0]  lane_sel;
    logic [63:0] wr_en;
    logic [63:0] valid_nxt;

    assign in_ready = rst_n && (state != FULL) && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        lane      = mode ? ptr : s;
        grp_sel   = 8'd1 << lane[5:3];
        lane_sel  = 8'd1 << lane[2:0];
        valid_nxt = y_valid | wr_en;
    end

    // Two-level decode: group strobe ANDed with lane-in-group strobe.
    for (genvar g = 0; g < 8; g++) begin : g_grp
        for (genvar l = 0; l < 8; l++) begin : g_lane
            assign wr_en[g*8+l] = accept && grp_sel[g] && lane_sel[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= {64{RST_VAL}};
            y_valid    <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
            state      <= IDLE;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                y       <= {64{RST_VAL}};
                y_valid <= '0;
                ptr     <= '0;
                state   <= IDLE;
            end else if (state == FULL) begin
                // Lane data is held across the ack; only the valid flags restart.
                if (frame_ack) begin
                    y_valid <= '0;
                    ptr     <= '0;
                    state   <= IDLE;
                end
            end else if (accept) begin
                for (int k = 0; k < 64; k++) begin
                    if (wr_en[k]) y[k*DATA_W +: DATA_W] <= din;
                end
                y_valid <= valid_nxt;
                if (mode) ptr <= ptr + 6'd1;
                if (&valid_nxt) begin
                    state      <= FULL;
                    frame_done <= 1'b1;
                end else begin
                    state <= FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1x64_framer.sv
// Directed bench for demux_1x64_framer with DATA_W=1, RST_VAL=0.
module tb_demux_1x64_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  s = '0;
    logic        mode = 1'b0;
    logic        clear = 1'b0;
    logic        frame_ack = 1'b0;
    logic [63:0] y;
    logic [63:0] y_valid;
    logic [5:0]  ptr;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int fd_total = 0;
    int fd0;
    logic [63:0] exp_y;

    demux_1x64_framer #(.DATA_W(1), .RST_VAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .mode(mode), .clear(clear), .frame_ack(frame_ack),
        .y(y), .y_valid(y_valid), .ptr(ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (frame_done) fd_total++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic m, input logic [5:0] sel, input logic d);
        mode = m; s = sel; din = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_y", y, 64'h0);
        chk("rst_y_valid", y_valid, 64'h0);
        chk("rst_ptr", ptr, 64'd0);
        chk("rst_frame_done", frame_done, 64'd0);
        chk("rst_in_ready", in_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_in_ready", in_ready, 64'd1);

        // Sequential fill, in_valid held high
        fd0 = fd_total;
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            din = i[0];
            @(negedge clk);
            if (i == 62) chk("fd_early", frame_done, 64'd0);
            if (i == 63) chk("fd_after_last", frame_done, 64'd1);
        end
        chk("fill_y", y, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("fill_y_valid", y_valid, {64{1'b1}});
        chk("fill_ptr_wrap", ptr, 64'd0);
        chk("fill_in_ready", in_ready, 64'd0);

        // Stall in FULL, then acknowledge
        din = 1'b1;
        repeat (5) @(negedge clk);
        chk("fill_fd_count", fd_total - fd0, 64'd1);
        chk("stall_y", y, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("stall_in_ready", in_ready, 64'd0);
        in_valid = 1'b0; frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_y_valid", y_valid, 64'h0);
        chk("ack_in_ready", in_ready, 64'd1);
        chk("ack_y_held", y, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("ack_ptr", ptr, 64'd0);

        // Addressed overwrite
        fd0 = fd_total;
        beat(1'b0, 6'd37, 1'b1);
        beat(1'b0, 6'd37, 1'b0);
        beat(1'b0, 6'd0, 1'b1);
        exp_y = 64'hAAAA_AAAA_AAAA_AAAA;
        exp_y[37] = 1'b0;
        exp_y[0] = 1'b1;
        chk("addr_y", y, exp_y);
        chk("addr_y_valid", y_valid, (64'd1 << 37) | 64'd1);
        chk("addr_ptr", ptr, 64'd0);
        chk("addr_no_fd", fd_total - fd0, 64'd0);

        // Plain clear
        clear = 1'b1;
        #1 chk("clear_in_ready", in_ready, 64'd0);
        @(negedge clk);
        clear = 1'b0;
        chk("clear_y", y, 64'h0);
        chk("clear_y_valid", y_valid, 64'h0);

        // Mixed mode
        beat(1'b1, 6'd0, 1'b1);
        beat(1'b1, 6'd0, 1'b1);
        beat(1'b1, 6'd0, 1'b1);
        beat(1'b0, 6'd2, 1'b0);
        chk("mix_ptr", ptr, 64'd3);
        chk("mix_y", y, 64'h3);
        chk("mix_y_valid", y_valid, 64'h7);
        for (int i = 0; i < 5; i++) beat(1'b1, 6'd0, 1'b1);
        chk("mix8_y", y, 64'hFB);
        chk("mix8_y_valid", y_valid, 64'hFF);
        chk("mix8_ptr", ptr, 64'd8);

        // Clear wins over a presented beat
        clear = 1'b1; in_valid = 1'b1; mode = 1'b0; s = 6'd10; din = 1'b1;
        #1 chk("clrpri_in_ready", in_ready, 64'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clrpri_y_valid", y_valid, 64'h0);
        chk("clrpri_ptr", ptr, 64'd0);
        chk("clrpri_y", y, 64'h0);

        // Async reset mid-frame
        for (int i = 0; i < 20; i++) beat(1'b1, 6'd0, 1'b1);
        chk("pre_rst_y", y, 64'hF_FFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y", y, 64'h0);
        chk("arst_y_valid", y_valid, 64'h0);
        chk("arst_ptr", ptr, 64'd0);
        chk("arst_in_ready", in_ready, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh fill; frame_ack on the completing beat must be ignored
        fd0 = fd_total;
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            din = ~i[0];
            frame_ack = (i == 63);
            @(negedge clk);
        end
        in_valid = 1'b0; frame_ack = 1'b0;
        @(negedge clk);
        chk("refill_fd_count", fd_total - fd0, 64'd1);
        chk("refill_y", y, 64'h5555_5555_5555_5555);
        chk("refill_still_full", in_ready, 64'd0);
        chk("refill_y_valid", y_valid, {64{1'b1}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
